// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for a 5-stage in-order core.
//
// Decides, every cycle, whether the front end advances, stalls or flushes:
//   * load-use hazards insert a single bubble into ID/EX,
//   * a taken branch in ID squashes the instruction in IF/ID,
//   * a multi-cycle mult/div freezes IF, ID and ID/EX for MD_LATENCY-1 cycles
//     and then releases the pipeline with a one-cycle md_done pulse.
// Also keeps a saturating count of cycles in which the PC was held.
//
// Parameters
//   MD_LATENCY  total mult/div latency in cycles (2..255)
//   CNT_W       width of the stall performance counter
// Ports
//   clock, reset        clock and asynchronous active-high reset
//   idex_memread        ID/EX instruction is a load
//   idex_rt             destination register of the ID/EX instruction
//   ifid_rs, ifid_rt    source fields of the IF/ID instruction
//   ifid_uses_rt        IF/ID instruction reads rt
//   branch_taken        branch in ID resolved taken
//   md_start            mult/div entering EX
//   pc_write            PC load enable
//   ifid_write          IF/ID load enable
//   ifid_flush          IF/ID replaced by a NOP at next edge
//   idex_bubble         ID/EX loads zeroed control fields at next edge
//   idex_hold           ID/EX keeps its contents at next edge
//   md_busy             mult/div operation in progress (registered)
//   md_done             one-cycle pulse when the mult/div releases the pipe
//   stall_count         saturating count of cycles with pc_write low
module hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             branch_taken,
    input  logic             md_start,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    // The md_start cycle itself is the first frozen cycle, so the counter
    // only has to cover the remaining MD_LATENCY-1 cycles.
    localparam logic [7:0]       CNT_LOAD = 8'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;
    logic       load_use;

    // Register 0 is hard-wired to zero, so a load targeting it never hazards.
    assign load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) ||
                       (ifid_uses_rt && (idex_rt == ifid_rt)));

    // ---------------- state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RUN: begin
                if (md_start) begin
                    state_next = MD_BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                // cnt==0 cannot occur in normal operation; treat it as a
                // release so the FSM can never lock up in MD_BUSY.
                if (cnt_reg > 8'd1) begin
                    cnt_next = cnt_reg - 8'd1;
                end else begin
                    state_next = RUN;
                    cnt_next   = 8'd0;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        idex_hold   = 1'b0;
        md_done     = 1'b0;
        // While reset is held the pipeline sees plain pass-through controls.
        if (!reset) begin
            case (state_reg)
                RUN: begin
                    if (md_start) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_hold  = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (branch_taken) begin
                        ifid_flush = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (cnt_reg > 8'd1) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_hold  = 1'b1;
                    end else begin
                        md_done = 1'b1;
                    end
                end
                default: begin
                    pc_write = 1'b1;
                end
            endcase
        end
    end

    assign md_busy = (state_reg == MD_BUSY);

    // ---------------- stall performance counter ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
